// File: rtl/ad9516_spi_resp_if.sv
// Bus bundle between the AD9516 SPI responder and its environment.
//  slave  : view used by the responder (SPI pins in, SDO out, register bank strobes out)
//  master : view used by the config master / register bank side
interface ad9516_spi_resp_if #(
  parameter int unsigned ADDR_W = 13
);
  logic              spi_cs_n;
  logic              spi_sclk;
  logic              spi_sdi;
  logic              spi_sdo;
  logic              spi_sdo_oe;
  logic              reg_wr_en;
  logic              reg_rd_en;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wr_data;
  logic [7:0]        reg_rd_data;
  logic              update_pulse;
  logic              frame_err;
  logic              busy;

  modport slave (
    input  spi_cs_n, spi_sclk, spi_sdi, reg_rd_data,
    output spi_sdo, spi_sdo_oe, reg_wr_en, reg_rd_en, reg_addr, reg_wr_data,
           update_pulse, frame_err, busy
  );

  modport master (
    output spi_cs_n, spi_sclk, spi_sdi, reg_rd_data,
    input  spi_sdo, spi_sdo_oe, reg_wr_en, reg_rd_en, reg_addr, reg_wr_data,
           update_pulse, frame_err, busy
  );
endinterface

// File: rtl/ad9516_spi_resp.sv
// AD9516 serial-port responder: oversamples CS/SCLK/SDI in the clk domain, decodes
// 16-bit instruction + data byte frames (MSB first) into register write/read strobes
// and shifts readback bytes out on SDO.
//  clk, rst : system clock, asynchronous active-high reset
//  bus      : slave modport (SPI pins, register bank strobes, update/error/busy flags)
module ad9516_spi_resp #(
  parameter int unsigned       ADDR_W      = 13,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [ADDR_W-1:0] UPDATE_ADDR = 13'h232
) (
  input  logic              clk,
  input  logic              rst,
  ad9516_spi_resp_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, INSTR, WDATA, RDATA, DONE} state_t;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, sdi_sync;
  logic                   cs_d, sclk_d;
  logic                   cs_s, sclk_s, sdi_s;
  logic                   cs_fall, cs_rise, sclk_rise_c, sclk_fall_c;

  state_t            state, state_n;
  logic [3:0]        bit_cnt, bit_cnt_n;
  logic [15:0]       shift, shift_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [1:0]        left, left_n;
  logic              stream, stream_n;
  logic [7:0]        sdo_sr, sdo_n;

  logic              wr_en_q, wr_en_n;
  logic              rd_en_q, rd_en_n;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_n;
  logic [7:0]        wr_data_q, wr_data_n;
  logic              upd_q, upd_n;
  logic              err_q, err_n;
  logic              busy_q, busy_n;
  logic              oe_q, oe_n;

  // Pin synchronisers plus one history flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync   <= '0;
      sclk_sync <= '0;
      sdi_sync  <= '0;
      cs_d      <= 1'b0;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], bus.spi_sdi};
      cs_d      <= cs_sync[SYNC_STAGES-1];
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign sdi_s   = sdi_sync[SYNC_STAGES-1];
  assign cs_fall = ~cs_s & cs_d;
  assign cs_rise = cs_s & ~cs_d;
  // Gated on the previous CS sample so an SCLK edge coinciding with CS release still counts
  assign sclk_rise_c = sclk_s & ~sclk_d & ~cs_d;
  assign sclk_fall_c = ~sclk_s & sclk_d & ~cs_d;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      addr       <= '0;
      left       <= '0;
      stream     <= 1'b0;
      sdo_sr     <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      reg_addr_q <= '0;
      wr_data_q  <= '0;
      upd_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      addr       <= addr_n;
      left       <= left_n;
      stream     <= stream_n;
      sdo_sr     <= sdo_n;
      wr_en_q    <= wr_en_n;
      rd_en_q    <= rd_en_n;
      reg_addr_q <= reg_addr_n;
      wr_data_q  <= wr_data_n;
      upd_q      <= upd_n;
      err_q      <= err_n;
      busy_q     <= busy_n;
      oe_q       <= oe_n;
    end
  end

  // Frame decode: next state and next output values
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    addr_n     = addr;
    left_n     = left;
    stream_n   = stream;
    sdo_n      = sdo_sr;
    wr_en_n    = 1'b0;
    rd_en_n    = 1'b0;
    reg_addr_n = reg_addr_q;
    wr_data_n  = wr_data_q;
    upd_n      = 1'b0;
    err_n      = 1'b0;
    busy_n     = busy_q;
    oe_n       = oe_q;

    // Read data is valid in the same clk the read strobe is presented
    if (rd_en_q) sdo_n = bus.reg_rd_data;

    unique case (state)
      IDLE: begin
        if (cs_fall) begin
          state_n   = INSTR;
          bit_cnt_n = '0;
          shift_n   = '0;
          busy_n    = 1'b1;
        end
      end
      INSTR: begin
        if (sclk_rise_c) begin
          shift_n   = {shift[14:0], sdi_s};
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) begin
            addr_n   = shift_n[ADDR_W-1:0];
            left_n   = shift_n[14:13];
            stream_n = &shift_n[14:13];
            if (shift_n[15]) begin
              state_n    = RDATA;
              rd_en_n    = 1'b1;
              reg_addr_n = shift_n[ADDR_W-1:0];
              oe_n       = 1'b1;
            end else begin
              state_n = WDATA;
            end
          end
        end
      end
      WDATA: begin
        if (sclk_rise_c) begin
          shift_n   = {shift[14:0], sdi_s};
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            bit_cnt_n  = '0;
            wr_en_n    = 1'b1;
            reg_addr_n = addr;
            wr_data_n  = shift_n[7:0];
            upd_n      = (addr == UPDATE_ADDR) && shift_n[0];
            addr_n     = addr - ADDR_W'(1);
            left_n     = left - 2'd1;
            if (!stream && left == 2'd0) state_n = DONE;
          end
        end
      end
      RDATA: begin
        // First fall of each byte leaves bit7 in place; later falls advance
        if (sclk_fall_c && bit_cnt != 4'd0) sdo_n = {sdo_sr[6:0], 1'b0};
        if (sclk_rise_c) begin
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            bit_cnt_n = '0;
            addr_n    = addr - ADDR_W'(1);
            left_n    = left - 2'd1;
            if (!stream && left == 2'd0) begin
              state_n = DONE;
              oe_n    = 1'b0;
              sdo_n   = '0;
            end else begin
              rd_en_n    = 1'b1;
              reg_addr_n = addr - ADDR_W'(1);
            end
          end
        end
      end
      DONE: begin
        oe_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase

    // CS release aborts any frame; a byte completing in the same clk is kept
    if (cs_rise && state != IDLE) begin
      state_n = IDLE;
      busy_n  = 1'b0;
      oe_n    = 1'b0;
      sdo_n   = '0;
      rd_en_n = 1'b0;
      err_n   = (state == INSTR || state == WDATA || state == RDATA) && (bit_cnt_n != 4'd0);
    end
  end

  assign bus.spi_sdo      = sdo_sr[7];
  assign bus.spi_sdo_oe   = oe_q;
  assign bus.reg_wr_en    = wr_en_q;
  assign bus.reg_rd_en    = rd_en_q;
  assign bus.reg_addr     = reg_addr_q;
  assign bus.reg_wr_data  = wr_data_q;
  assign bus.update_pulse = upd_q;
  assign bus.frame_err    = err_q;
  assign bus.busy         = busy_q;

endmodule
